kmp_string_scan: RTL and testbench

Streaming Knuth-Morris-Pratt matcher directly downstream of the failure-function stage in the string-matching engine. Once the pattern and its failure table are valid, it consumes the target string one byte per accepted cycle with ready/valid backpressure. It reports every occurrence of the pattern as a pulse carrying the start index, then a summary (found flag, first index, count) when the string ends.

---
 rtl/kmp_string_scan.sv | 146 ++++++++++++++
 tb/tb_kmp_string_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/kmp_string_scan.sv
// Streaming KMP matcher: consumes the target string one byte per accepted
// cycle, pulses o_match with the start index of every occurrence, and
// presents a found/first/count summary once the final byte is taken.
module kmp_string_scan #(
  parameter int MAX_PATTERN = 8,
  parameter int MAX_PAT_ADD = 3,
  parameter int MAX_STRING  = 32,
  parameter int MAX_STR_ADD = 5,
  parameter int BYTE        = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ff_valid,
  input  logic [MAX_PATTERN*BYTE-1:0]      pattern,
  input  logic [MAX_PAT_ADD-1:0]           last_pat_idx,
  input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func,
  input  logic                             str_valid,
  input  logic [BYTE-1:0]                  str_char,
  input  logic                             str_last,
  output logic                             str_ready,
  output logic                             o_match,
  output logic [MAX_STR_ADD-1:0]           o_match_idx,
  output logic                             o_found,
  output logic [MAX_STR_ADD-1:0]           o_first_idx,
  output logic [MAX_STR_ADD:0]             o_match_cnt,
  output logic                             o_valid
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SCAN = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t                   state_q, state_d;
  logic [MAX_PAT_ADD-1:0]   j_q, j_d;
  logic [MAX_STR_ADD-1:0]   pos_q, pos_d;
  logic                     match_d, found_d, valid_d;
  logic [MAX_STR_ADD-1:0]   midx_d, first_d;
  logic [MAX_STR_ADD:0]     cnt_d;

  logic [BYTE-1:0]          p_char;
  logic [MAX_PAT_ADD-1:0]   j_prev, fail_at_j, fail_at_last;
  logic                     in_scan, hit, accept, at_last, match, final_byte;
  logic [MAX_STR_ADD-1:0]   start;

  // Datapath views of the current pattern position and the fail table.
  always_comb begin
    j_prev       = j_q - 1'b1;
    p_char       = pattern[j_q*BYTE +: BYTE];
    fail_at_j    = fail_func[j_prev*MAX_PAT_ADD +: MAX_PAT_ADD];
    fail_at_last = fail_func[last_pat_idx*MAX_PAT_ADD +: MAX_PAT_ADD];
    in_scan      = (state_q == SCAN) && ff_valid;
    hit          = (str_char == p_char);
    // A mismatch with j>0 must fall back before the byte can be judged.
    str_ready    = in_scan && (hit || (j_q == '0));
    accept       = str_valid && str_ready;
    at_last      = (j_q == last_pat_idx);
    match        = accept && hit && at_last;
    start        = pos_q - MAX_STR_ADD'(last_pat_idx);
    final_byte   = str_last || (pos_q == MAX_STR_ADD'(MAX_STRING - 1));
  end

  // Next-state and next-value logic for the FSM and scan registers.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    pos_d   = pos_q;
    found_d = o_found;
    first_d = o_first_idx;
    cnt_d   = o_match_cnt;
    match_d = 1'b0;
    midx_d  = o_match_idx;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ff_valid) begin
          state_d = SCAN;
          j_d     = '0;
          pos_d   = '0;
          found_d = 1'b0;
          first_d = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (!ff_valid) begin
          state_d = IDLE;
        end else if (accept) begin
          if (!hit)          j_d = '0;
          else if (at_last)  j_d = fail_at_last;
          else               j_d = j_q + 1'b1;
          // pos saturates on the final byte so it never wraps.
          if (final_byte) state_d = DONE;
          else            pos_d   = pos_q + 1'b1;
          if (match) begin
            match_d = 1'b1;
            midx_d  = start;
            cnt_d   = o_match_cnt + 1'b1;
            if (!o_found) begin
              found_d = 1'b1;
              first_d = start;
            end
          end
        end else if (!hit && (j_q != '0)) begin
          j_d = fail_at_j;
        end
      end
      DONE: begin
        if (!ff_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Scan position and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      j_q         <= '0;
      pos_q       <= '0;
      o_match     <= 1'b0;
      o_match_idx <= '0;
      o_found     <= 1'b0;
      o_first_idx <= '0;
      o_match_cnt <= '0;
      o_valid     <= 1'b0;
    end else begin
      j_q         <= j_d;
      pos_q       <= pos_d;
      o_match     <= match_d;
      o_match_idx <= midx_d;
      o_found     <= found_d;
      o_first_idx <= first_d;
      o_match_cnt <= cnt_d;
      o_valid     <= valid_d;
    end
  end

endmodule

// File: tb/tb_kmp_string_scan.sv
// Directed bench for kmp_string_scan: a naive search over each string fills
// a queue of expected match indices, popped as o_match pulses appear.
module tb_kmp_string_scan;

  localparam int MAX_PATTERN = 8;
  localparam int MAX_PAT_ADD = 3;
  localparam int MAX_STRING  = 32;
  localparam int MAX_STR_ADD = 5;
  localparam int BYTE        = 8;

  logic clk = 1'b0;
  logic reset, ff_valid;
  logic [MAX_PATTERN*BYTE-1:0] pattern;
  logic [MAX_PAT_ADD-1:0] last_pat_idx;
  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func;
  logic str_valid, str_last, str_ready;
  logic [BYTE-1:0] str_char;
  logic o_match, o_found, o_valid;
  logic [MAX_STR_ADD-1:0] o_match_idx, o_first_idx;
  logic [MAX_STR_ADD:0] o_match_cnt;

  always #5 clk = ~clk;

  kmp_string_scan #(
    .MAX_PATTERN(MAX_PATTERN), .MAX_PAT_ADD(MAX_PAT_ADD), .MAX_STRING(MAX_STRING),
    .MAX_STR_ADD(MAX_STR_ADD), .BYTE(BYTE)
  ) dut (
    .clk(clk), .reset(reset), .ff_valid(ff_valid), .pattern(pattern),
    .last_pat_idx(last_pat_idx), .fail_func(fail_func), .str_valid(str_valid),
    .str_char(str_char), .str_last(str_last), .str_ready(str_ready),
    .o_match(o_match), .o_match_idx(o_match_idx), .o_found(o_found),
    .o_first_idx(o_first_idx), .o_match_cnt(o_match_cnt), .o_valid(o_valid)
  );

  int checks = 0;
  int errors = 0;
  string pat_s;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Load a pattern and build its fail table by brute force.
  task automatic set_pattern(input string p);
    int best;
    bit ok;
    pat_s = p;
    pattern = '0;
    fail_func = '0;
    last_pat_idx = MAX_PAT_ADD'(p.len() - 1);
    for (int k = 0; k < p.len(); k++) begin
      pattern[k*BYTE +: BYTE] = p[k];
      best = 0;
      for (int l = 1; l <= k; l++) begin
        ok = 1'b1;
        for (int t = 0; t < l; t++)
          if (p[t] != p[k-l+1+t]) ok = 1'b0;
        if (ok) best = l;
      end
      fail_func[k*MAX_PAT_ADD +: MAX_PAT_ADD] = MAX_PAT_ADD'(best);
    end
  endtask

  task automatic check_match();
    int e;
    if (o_match === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_match", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("match_idx", 32'(o_match_idx), e);
      end
    end
  endtask

  // Drive one full job from IDLE; exp_stalls < 0 skips the stall count check.
  task automatic run_job(input string s, input bit use_last, input int exp_stalls);
    int plen, cnt, first, i, cyc, stalls;
    bit ok, acc, done;
    plen = pat_s.len();
    cnt = 0; first = 0;
    exp_q.delete();
    for (int st = 0; st + plen <= s.len(); st++) begin
      ok = 1'b1;
      for (int t = 0; t < plen; t++)
        if (s[st+t] != pat_s[t]) ok = 1'b0;
      if (ok) begin
        if (cnt == 0) first = st;
        cnt++;
        exp_q.push_back(st);
      end
    end
    ff_valid = 1'b1;
    #1;
    chk("ready_in_idle", 32'(str_ready), 0);
    @(posedge clk); @(negedge clk);
    i = 0; cyc = 0; stalls = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      str_valid = 1'b1;
      str_char  = s[i];
      str_last  = use_last && (i == s.len() - 1);
      #1;
      acc = str_ready;
      if (!acc) stalls++;
      @(posedge clk); @(negedge clk);
      cyc++;
      check_match();
      if (acc) begin
        if (i == s.len() - 1) done = 1'b1;
        i++;
      end
      if (!done) chk("valid_early", 32'(o_valid), 0);
    end
    if (!done) chk("job_timeout", 0, 1);
    str_valid = 1'b0;
    str_last  = 1'b0;
    chk("valid_rise", 32'(o_valid), 1);
    chk("found", 32'(o_found), (cnt > 0) ? 1 : 0);
    chk("match_cnt", 32'(o_match_cnt), cnt);
    if (cnt > 0) chk("first_idx", 32'(o_first_idx), first);
    if (exp_stalls >= 0) chk("stalls", stalls, exp_stalls);
    @(posedge clk); @(negedge clk);
    chk("match_one_cycle", 32'(o_match), 0);
    chk("valid_hold", 32'(o_valid), 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic end_job();
    ff_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("valid_clear", 32'(o_valid), 0);
    chk("ready_after_done", 32'(str_ready), 0);
  endtask

  task automatic feed(input byte c);
    str_valid = 1'b1;
    str_char  = c;
    @(posedge clk); @(negedge clk);
  endtask

  string s;

  initial begin
    reset = 1'b1; ff_valid = 1'b0; str_valid = 1'b0; str_char = '0; str_last = 1'b0;
    set_pattern("ABAB");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_match", 32'(o_match), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_cnt", 32'(o_match_cnt), 0);
    chk("rst_ready", 32'(str_ready), 0);
    reset = 1'b0;

    // Overlapping matches, no stalls.
    s = "ABABAB"; run_job(s, 1'b1, 0); end_job();
    // One fallback stall at byte 1.
    s = "AABAB"; run_job(s, 1'b1, 1); end_job();
    // Single-byte pattern, back-to-back pulses.
    set_pattern("C");
    s = "CCC"; run_job(s, 1'b1, 0); end_job();
    // No match.
    set_pattern("ABC");
    s = "XYZ"; run_job(s, 1'b1, 0); end_job();
    // Pattern longer than string.
    set_pattern("ABCD");
    s = "AB"; run_job(s, 1'b1, -1); end_job();
    // Implicit last at MAX_STRING bytes.
    set_pattern("AA");
    s = "";
    for (int k = 0; k < MAX_STRING; k++) s = {s, "A"};
    run_job(s, 1'b0, 0); end_job();

    // Abort by dropping ff_valid mid-string.
    set_pattern("C");
    ff_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    feed("C"); feed("X");
    ff_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_ready", 32'(str_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_valid_late", 32'(o_valid), 0);

    // Second job cut short by reset after two matches.
    ff_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    feed("C"); feed("C");
    str_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst2_match", 32'(o_match), 0);
    chk("rst2_idx", 32'(o_match_idx), 0);
    chk("rst2_found", 32'(o_found), 0);
    chk("rst2_first", 32'(o_first_idx), 0);
    chk("rst2_cnt", 32'(o_match_cnt), 0);
    chk("rst2_valid", 32'(o_valid), 0);
    chk("rst2_ready", 32'(str_ready), 0);
    reset = 1'b0;
    // Fresh job: summary must not carry over the aborted counts.
    s = "XCC"; run_job(s, 1'b1, 0); end_job();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
